rom_loader: RTL

//  Consumes the ROM-download byte stream from the OSD file loader (romIo/romWr/romA/romD)
//  and writes each byte into the external ROM/RAM memory through a req/ack memory port.

---
 rtl/rom_loader_pkg.sv | 22 ++
 rtl/rom_loader_fifo.sv | 68 ++++++
 rtl/rom_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg
//   Shared definitions for the ROM download path: loader FSM state encoding,
//   loader-side address width and the FIFO entry width helper
//   ({address, data} packed as one word).
package rom_loader_pkg;

  // Width of the byte address coming from the OSD file loader.
  localparam int ROM_A_W = 25;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    DRAIN   = 2'd2,
    HOLDING = 2'd3
  } loaderState_t;

  // One FIFO entry carries the memory address followed by the data byte.
  function automatic int entryWidth(input int aw);
    return aw + 8;
  endfunction

endpackage

// File: rtl/rom_loader_fifo.sv
// loader_fifo
//   Small synchronous FIFO between the download byte stream and the memory
//   write port. The head entry is always visible on dout. A push while full
//   is accepted only when a pop happens in the same cycle.
// Ports
//   clock  in   system clock
//   reset  in   asynchronous active-high reset (empties the FIFO)
//   push   in   write din this cycle
//   pop    in   drop the head entry this cycle
//   din    in   W-bit entry to write
//   dout   out  W-bit head entry
//   full   out  all 2**FAW entries occupied
//   empty  out  no entries
module loader_fifo #(
  parameter int W   = 27,
  parameter int FAW = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << FAW;

  logic [W-1:0]   mem [DEPTH];
  logic [FAW-1:0] wrPtr;
  logic [FAW-1:0] rdPtr;
  logic [FAW:0]   count;
  logic           doPush;
  logic           doPop;

  assign full   = (count == (FAW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign doPop  = pop & ~empty;
  // A simultaneous pop frees the slot this push needs.
  assign doPush = push & (~full | doPop);
  assign dout   = mem[rdPtr];

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (doPush) begin
      mem[wrPtr] <= din;
    end
  end

  // Pointers wrap naturally modulo 2**FAW.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_loader.sv
// rom_loader
//   Takes the ROM download byte stream from the OSD file loader and writes
//   each byte into external memory through a req/ack port, holding the core
//   in reset for the whole download plus HOLD cycles afterwards.
// Ports
//   clock      in   system clock
//   reset      in   asynchronous active-high reset
//   romIo      in   download active (level)
//   romWr      in   one-cycle byte strobe, meaningful while romIo=1
//   romA       in   25-bit byte address
//   romD       in   byte data
//   memReq     out  write request, held with memA/memD until memAck
//   memA       out  AW-bit write address
//   memD       out  write data
//   memAck     in   one-cycle accept from the memory controller
//   coreReset  out  core held in reset during a download
//   busy       out  FSM not idle
//   done       out  one-cycle pulse when coreReset falls
//   ovf        out  sticky: byte dropped, FIFO full
//   oor        out  sticky: byte dropped, address out of range
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int AW   = 19,
  parameter int FAW  = 2,
  parameter int HOLD = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 romIo,
  input  logic                 romWr,
  input  logic [ROM_A_W-1:0]   romA,
  input  logic [7:0]           romD,
  output logic                 memReq,
  output logic [AW-1:0]        memA,
  output logic [7:0]           memD,
  input  logic                 memAck,
  output logic                 coreReset,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  output logic                 oor
);

  localparam int W   = entryWidth(AW);
  localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;

  loaderState_t   state;
  logic           romIoReg;
  logic [HCW-1:0] holdCnt;

  logic           romRise;
  logic           romFall;
  logic           wrStrobe;
  logic           inRange;
  logic           fifoPush;
  logic           fifoPop;
  logic           fifoFull;
  logic           fifoEmpty;
  logic [W-1:0]   fifoDin;
  logic [W-1:0]   fifoDout;

  assign romRise  = romIo & ~romIoReg;
  assign romFall  = ~romIo & romIoReg;
  assign wrStrobe = romIo & romWr;
  assign inRange  = (romA[ROM_A_W-1:AW] == '0);
  // An ack only counts while a request is outstanding.
  assign fifoPop  = memReq & memAck;
  assign fifoPush = wrStrobe & inRange & (~fifoFull | fifoPop);
  assign fifoDin  = {romA[AW-1:0], romD};

  loader_fifo #(
    .W   (W),
    .FAW (FAW)
  ) uFifo (
    .clock (clock),
    .reset (reset),
    .push  (fifoPush),
    .pop   (fifoPop),
    .din   (fifoDin),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      romIoReg  <= 1'b0;
      holdCnt   <= '0;
      memReq    <= 1'b0;
      memA      <= '0;
      memD      <= '0;
      coreReset <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      oor       <= 1'b0;
    end else begin
      romIoReg <= romIo;
      done     <= 1'b0;

      // Memory port: one write outstanding at most. The head entry is
      // latched on issue and popped from the FIFO when acked.
      if (memReq) begin
        if (memAck) memReq <= 1'b0;
      end else if (!fifoEmpty) begin
        memReq <= 1'b1;
        memA   <= fifoDout[W-1:8];
        memD   <= fifoDout[7:0];
      end

      case (state)
        IDLE: begin
          if (romRise) begin
            state     <= LOAD;
            coreReset <= 1'b1;
            busy      <= 1'b1;
            ovf       <= 1'b0;
            oor       <= 1'b0;
          end
        end
        LOAD: begin
          if (romFall) state <= DRAIN;
        end
        DRAIN: begin
          // A fresh download resumes on top of whatever is still queued.
          if (romRise) begin
            state <= LOAD;
          end else if (fifoEmpty && !memReq) begin
            state   <= HOLDING;
            holdCnt <= '0;
          end
        end
        HOLDING: begin
          if (romRise) begin
            state <= LOAD;
          end else if (holdCnt == HCW'(HOLD - 1)) begin
            state     <= IDLE;
            coreReset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            holdCnt <= holdCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Sticky error flags; placed after the IDLE clear so a faulty byte
      // arriving with the romIo rise is still reported.
      if (wrStrobe && !inRange) oor <= 1'b1;
      if (wrStrobe && inRange && fifoFull && !fifoPop) ovf <= 1'b1;
    end
  end

endmodule
